// File: rtl/dom_rand_supplier_gf4.sv
// dom_rand_supplier_gf4: seeded 64-bit LFSR supplying Z/B masking randomness to a DOM GF(4) multiplier
module dom_rand_supplier_gf4 #(
  parameter int SHARES = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int RESEED_INTERVAL = 1024,
  localparam int Z_BITS = 2 * SHARES * (SHARES - 1),
  localparam int B_BITS = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 4 : 4 * SHARES,
  localparam int RND_BITS = Z_BITS + B_BITS,
  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1)
) (
  input  logic              ClkxCI,
  input  logic              RstxRI,
  input  logic [31:0]       SeedxDI,
  input  logic              SeedValidxSI,
  output logic              SeedReadyxSO,
  input  logic              ReseedxSI,
  output logic              ReseedReqxSO,
  output logic [Z_BITS-1:0] ZxDO,
  output logic [B_BITS-1:0] BxDO,
  output logic              RndValidxSO,
  input  logic              RndReadyxSI
);

  localparam logic [2:0] UNSEEDED  = 3'd0;
  localparam logic [2:0] SEED      = 3'd1;
  localparam logic [2:0] GEN       = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] EXHAUSTED = 3'd4;

  if (RND_BITS > 64 || SHARES < 2 || RESEED_INTERVAL < 1) begin : g_param_check
    $error("dom_rand_supplier_gf4: unsupported parameters (RND_BITS must be <= 64)");
  end

  logic [2:0]          StatexDP, stateNxt;
  logic [63:0]         LfsrxDP, lfsrNxt, stepStatexD;
  logic [CNT_W-1:0]    CntxDP, cntNxt, cntIncxD;
  logic [RND_BITS-1:0] chunkxD, rndNxt;
  logic                fbxD;

  // Unrolled RND_BITS LFSR steps; a zero state is lifted to 1 so it can never lock up
  always_comb begin
    stepStatexD = (LfsrxDP == '0) ? 64'h1 : LfsrxDP;
    chunkxD = '0;
    fbxD = 1'b0;
    for (int k = 0; k < RND_BITS; k++) begin
      fbxD = stepStatexD[63] ^ stepStatexD[62] ^ stepStatexD[60] ^ stepStatexD[59];
      chunkxD[k] = fbxD;
      stepStatexD = {stepStatexD[62:0], fbxD};
    end
  end

  // Seeding, generation and transfer accounting; reseed wins over a simultaneous transfer
  always_comb begin
    stateNxt = StatexDP;
    lfsrNxt = LfsrxDP;
    cntNxt = CntxDP;
    rndNxt = {BxDO, ZxDO};
    cntIncxD = CntxDP + CNT_W'(1);
    case (StatexDP)
      UNSEEDED:
        if (!ReseedxSI && SeedValidxSI && SeedReadyxSO) begin
          lfsrNxt[31:0] = SeedxDI;
          stateNxt = SEED;
        end
      SEED:
        if (ReseedxSI) stateNxt = UNSEEDED;
        else if (SeedValidxSI && SeedReadyxSO) begin
          lfsrNxt[63:32] = SeedxDI;
          stateNxt = GEN;
        end
      GEN: begin
        lfsrNxt = stepStatexD;
        rndNxt = chunkxD;
        cntNxt = '0;
        stateNxt = RUN;
      end
      RUN:
        if (ReseedxSI) begin
          stateNxt = UNSEEDED;
          rndNxt = '0;
          cntNxt = '0;
        end else if (RndValidxSO && RndReadyxSI) begin
          cntNxt = cntIncxD;
          if (cntIncxD < CNT_W'(RESEED_INTERVAL)) begin
            lfsrNxt = stepStatexD;
            rndNxt = chunkxD;
          end else begin
            rndNxt = '0;
            stateNxt = EXHAUSTED;
          end
        end
      default: stateNxt = UNSEEDED;
    endcase
  end

  // State and registered Moore outputs derived from the next state
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      StatexDP <= UNSEEDED;
      LfsrxDP <= '0;
      CntxDP <= '0;
      ZxDO <= '0;
      BxDO <= '0;
      RndValidxSO <= 1'b0;
      SeedReadyxSO <= 1'b0;
      ReseedReqxSO <= 1'b1;
    end else begin
      StatexDP <= stateNxt;
      LfsrxDP <= lfsrNxt;
      CntxDP <= cntNxt;
      {BxDO, ZxDO} <= rndNxt;
      RndValidxSO <= stateNxt == RUN;
      SeedReadyxSO <= stateNxt == UNSEEDED || stateNxt == SEED;
      ReseedReqxSO <= stateNxt == UNSEEDED || stateNxt == SEED || stateNxt == EXHAUSTED;
    end
  end

endmodule

// File: tb/tb_dom_rand_supplier_gf4.sv
// tb_dom_rand_supplier_gf4: checks two configurations against a bit-sequence recurrence model
module tb_dom_rand_supplier_gf4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] seedA = '0, seedC = '0;
  logic seedValidA = 1'b0, seedValidC = 1'b0, reseedA = 1'b0, reseedC = 1'b0, readyA = 1'b0, readyC = 1'b0;
  logic seedReadyA, seedReadyC, reseedReqA, reseedReqC, validA, validC;
  logic [3:0] zA, bA;
  logic [11:0] zC, bC;

  int total = 0;
  int passed = 0;
  bit xq[$];
  int mj = 0;

  dom_rand_supplier_gf4 #(.SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .RESEED_INTERVAL(1024)) dutA (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seedA), .SeedValidxSI(seedValidA), .SeedReadyxSO(seedReadyA),
    .ReseedxSI(reseedA), .ReseedReqxSO(reseedReqA), .ZxDO(zA), .BxDO(bA),
    .RndValidxSO(validA), .RndReadyxSI(readyA));

  dom_rand_supplier_gf4 #(.SHARES(3), .FIRST_ORDER_OPTIMIZATION(0), .RESEED_INTERVAL(4)) dutC (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seedC), .SeedValidxSI(seedValidC), .SeedReadyxSO(seedReadyC),
    .ReseedxSI(reseedC), .ReseedReqxSO(reseedReqC), .ZxDO(zC), .BxDO(bC),
    .RndValidxSO(validC), .RndReadyxSI(readyC));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] rnd(input bit s);
    return s ? 64'({bC, zC}) : 64'({bA, zA});
  endfunction
  function automatic logic vld(input bit s);
    return s ? validC : validA;
  endfunction
  function automatic logic srdy(input bit s);
    return s ? seedReadyC : seedReadyA;
  endfunction
  function automatic logic rreq(input bit s);
    return s ? reseedReqC : reseedReqA;
  endfunction

  task automatic drive(input bit s, input logic [31:0] w, input logic v, input logic rs, input logic rd);
    if (s) begin
      seedC = w; seedValidC = v; reseedC = rs; readyC = rd;
    end else begin
      seedA = w; seedValidA = v; reseedA = rs; readyA = rd;
    end
  endtask

  // Output bit sequence x: x[0..63] is the seed, oldest bit (S[63]) first; x[m] = x[m-64]^x[m-63]^x[m-61]^x[m-60]
  task automatic mseed(input logic [63:0] v);
    logic [63:0] s;
    s = (v == '0) ? 64'd1 : v;
    xq.delete();
    mj = 0;
    for (int i = 0; i < 64; i++) xq.push_back(s[63-i]);
  endtask

  task automatic mchunk(input int r, input bit adv, output logic [63:0] c);
    c = '0;
    for (int k = 0; k < r; k++) begin
      int n;
      n = 64 + mj * r + k;
      while (xq.size() <= n)
        xq.push_back(xq[xq.size()-64] ^ xq[xq.size()-63] ^ xq[xq.size()-61] ^ xq[xq.size()-60]);
      c[k] = xq[n];
    end
    if (adv) mj++;
  endtask

  task automatic seed(input bit s, input logic [63:0] v);
    int t;
    t = 0;
    while (!srdy(s) && t < 20) begin @(negedge clk); t++; end
    chk("seed_ready", 64'(srdy(s)), 64'd1);
    drive(s, v[31:0], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(s, v[63:32], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(s, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("gen_not_valid", 64'(vld(s)), 64'd0);
    @(negedge clk);
    chk("first_valid_latency", 64'(vld(s)), 64'd1);
    mseed(v);
  endtask

  task automatic take(input bit s, input string nm, output logic [63:0] obs);
    logic [63:0] c;
    int t;
    t = 0;
    drive(s, 32'd0, 1'b0, 1'b0, 1'b1);
    while (!vld(s) && t < 20) begin @(negedge clk); t++; end
    if (t == 20) chk("valid_wait", 64'(vld(s)), 64'd1);
    obs = rnd(s);
    mchunk(s ? 24 : 8, 1'b1, c);
    chk(nm, obs, c);
    @(negedge clk);
  endtask

  task automatic reseed_xfer(input bit s);
    chk("reseed_pre_valid", 64'(vld(s)), 64'd1);
    drive(s, 32'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(s, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("reseed_valid", 64'(vld(s)), 64'd0);
    chk("reseed_rnd", rnd(s), 64'd0);
    chk("reseed_req", 64'(rreq(s)), 64'd1);
    chk("reseed_seed_ready", 64'(srdy(s)), 64'd1);
  endtask

  typedef struct {
    logic [63:0] seed;
    logic [63:0] exp8;
  } vec_t;

  initial begin
    vec_t tbl[3];
    logic [63:0] obs, hold, c, rs;
    logic r;
    tbl[0] = '{seed: 64'h1, exp8: 64'hD800_0000_0000_0000};
    tbl[1] = '{seed: 64'h0, exp8: 64'hD800_0000_0000_0000};
    tbl[2] = '{seed: 64'h8000_0000_0000_0000, exp8: 64'hB000_0000_0000_0001};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_hold_valid", 64'(vld(s[0])), 64'd0);
      chk("rst_hold_req", 64'(rreq(s[0])), 64'd1);
      chk("rst_hold_seed_ready", 64'(srdy(s[0])), 64'd0);
      chk("rst_hold_rnd", rnd(s[0]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 64'(vld(s[0])), 64'd0);
      chk("rst_req", 64'(rreq(s[0])), 64'd1);
      chk("rst_seed_ready", 64'(srdy(s[0])), 64'd1);
      chk("rst_rnd", rnd(s[0]), 64'd0);
    end

    for (int i = 0; i < 3; i++) begin
      seed(1'b0, tbl[i].seed);
      for (int j = 0; j < 8; j++) begin
        take(1'b0, "model_chunk", obs);
        chk("table_chunk", obs, 64'(tbl[i].exp8[8*j +: 8]));
      end
      if (i == 0) for (int j = 8; j < 1000; j++) take(1'b0, "model_xfer", obs);
      reseed_xfer(1'b0);
    end

    rs = {$urandom, $urandom};
    seed(1'b0, rs);
    repeat (3) take(1'b0, "pre_stall", obs);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    hold = rnd(1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_stable", rnd(1'b0), hold);
      chk("stall_valid", 64'(vld(1'b0)), 64'd1);
    end
    take(1'b0, "after_stall", obs);

    for (int n = 0; n < 300; n++) begin
      r = 1'($urandom_range(0, 1));
      drive(1'b0, 32'd0, 1'b0, 1'b0, r);
      chk("rand_valid", 64'(vld(1'b0)), 64'd1);
      mchunk(8, r, c);
      chk("rand_chunk", rnd(1'b0), c);
      @(negedge clk);
    end
    reseed_xfer(1'b0);

    rs = {$urandom, $urandom};
    seed(1'b1, rs);
    repeat (4) take(1'b1, "c_chunk", obs);
    chk("exhaust_valid", 64'(vld(1'b1)), 64'd0);
    chk("exhaust_rnd", rnd(1'b1), 64'd0);
    chk("exhaust_req", 64'(rreq(1'b1)), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("exhaust_no_valid", 64'(vld(1'b1)), 64'd0);
      chk("exhaust_req_held", 64'(rreq(1'b1)), 64'd1);
    end

    seed(1'b1, rs);
    repeat (2) take(1'b1, "c_restart", obs);
    reseed_xfer(1'b1);

    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    rs = {$urandom, $urandom};
    seed(1'b1, rs);
    repeat (4) take(1'b1, "c_after_seed_restart", obs);
    chk("exhaust2_valid", 64'(vld(1'b1)), 64'd0);

    seed(1'b0, {$urandom, $urandom});
    repeat (2) take(1'b0, "pre_async_rst", obs);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(vld(1'b0)), 64'd0);
    chk("async_rst_rnd", rnd(1'b0), 64'd0);
    chk("async_rst_req", 64'(rreq(1'b0)), 64'd1);
    chk("async_rst_seed_ready", 64'(srdy(1'b0)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_seed_ready", 64'(srdy(1'b0)), 64'd1);
    chk("post_rst_valid", 64'(vld(1'b0)), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
